fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage upstream of the single-cycle core datapath.
- Issues sequential word fetches to a handshaked instruction memory and buffers returned words in a small prefetch FIFO.
- Presents {instruction, pc} to the decode/execute logic with valid/ready.
- Handles taken-branch redirects, including a fetch in flight at redirect time.

Parameters:
- BOOT_ADDRESS, 32'h00000000, fetch PC loaded on reset
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  fetch address, word aligned
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid this cycle
- mem_rdata  in  32  fetched instruction word
- redirect_valid  in  1  branch taken; restart fetch at redirect_addr
- redirect_addr  in  32  new fetch PC
- instr_valid  out  1  FIFO head valid
- instr_out  out  32  FIFO head instruction
- instr_pc  out  32  address of instr_out
- instr_ready  in  1  consumer accepts head this cycle

Behaviour:
- Reset: fetch_pc = BOOT_ADDRESS; FIFO empty; FSM = IDLE; mem_req = 0; mem_addr = BOOT_ADDRESS; instr_valid = 0; instr_out = 0; instr_pc = 0.
- Reset asserted mid-fetch: all state is cleared. A mem_ack arriving afterwards in IDLE is ignored.
- Memory handshake:
  - At most one outstanding request.
  - mem_req and mem_addr are registered.
  - mem_req and mem_addr stay stable until the cycle mem_ack = 1.
  - mem_req deasserts the cycle after ack unless a new fetch issues back-to-back.
- Issue rule: a request may issue only when FIFO count plus outstanding is less than FIFO_DEPTH.
- FSM states:
  - IDLE: no outstanding fetch. If the issue rule holds and redirect_valid = 0: mem_req = 1, mem_addr = fetch_pc, go to WAIT.
  - WAIT: fetch outstanding; data is kept. On mem_ack, push {mem_rdata, mem_addr} and set fetch_pc = mem_addr + 4 (32-bit wrap, FFFFFFFC to 00000000). If the issue rule still holds counting this push, reissue immediately and stay in WAIT; otherwise go to IDLE.
  - DRAIN: fetch outstanding; data is discarded. On mem_ack, drop the data and go to IDLE.
- Latency: mem_ack in cycle N gives instr_valid = 1 in cycle N+1. There is no combinational bypass from mem_rdata.
- FIFO output: pop when instr_valid and instr_ready. Push and pop in the same cycle are both honoured and count is unchanged. The full and empty flags derive from count.
- Redirect (redirect_valid = 1):
  - FIFO is flushed; instr_valid = 0 the next cycle.
  - fetch_pc = {redirect_addr[31:2], 2'b00}.
  - instr_ready is ignored that cycle.
  - From WAIT without ack this cycle: go to DRAIN.
  - From WAIT with ack this cycle: data dropped; go to IDLE.
  - From DRAIN: update target; stay in DRAIN, or go to IDLE if acked.
  - From IDLE: the request at the new PC issues the following cycle.
- Redirect beats push and pop when simultaneous.
- Consecutive redirects: the last one wins.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - fetch_misaligned is sticky-set when redirect_valid = 1 and redirect_addr[1:0] != 0.
  - The fetch still proceeds at the aligned address.
- Undefined: the port is absent and low bits are silently cleared.

Decomposition:
- Shared package fetch_pkg holds:
  - the FSM state typedef fetch_state_t (IDLE, WAIT, DRAIN)
  - the constant INSTR_WIDTH = 32
  - the constant PC_STEP = 4
- One natural sub-module, fetch_fifo: synchronous FIFO of {pc, instr}, 64 bits wide, with flush, push, pop, count, and registered head outputs.

Test Plan:
- Reset release, memory acks 1 cycle after each request with rdata = addr ^ 32'hA5A5A5A5, instr_ready = 1 -> instr_pc sequence 0, 4, 8, 12 and instr_out values match that pattern, with no gaps after the first.
- instr_ready = 0 for 20 cycles -> exactly 4 entries are buffered, mem_req stays 0, and PCs 0 to C are held in order once ready rises.
- Redirect to 0x100 while the request for 0x8 is unacked, ack arriving 3 cycles later -> word 0x8 is never presented, the next mem_addr is 0x100, and the first instr_pc after that is 0x100.
- Redirect to 0x200 in the same cycle as the ack for 0x10, with instr_ready = 1 -> 0x10 is discarded, the FIFO is empty the next cycle, and the next fetch is 0x200.
- Redirect to 0xFFFFFFF8 -> PCs FFFFFFF8, FFFFFFFC, 00000000.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> fetch at 0x100 and fetch_misaligned = 1 until reset.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: FSM state type and constants shared by the fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} fetch_state_t;
  localparam int INSTR_WIDTH = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous {pc, instr} prefetch FIFO with flush and registered head.
module fetch_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [63:0]   din,
  output logic [AW:0]   count,
  output logic          valid,
  output logic [63:0]   dout
);
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign dout = mem[rd];
  assign do_pop = pop && valid;
  assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr] <= din;
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction prefetch into a small FIFO with branch redirect.
// Defining FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misaligned flag for unaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_addr,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                   fetch_misaligned,
`endif
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [31:0]            instr_pc,
  input  logic                   instr_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state, state_n;
  logic [31:0] fetch_pc, pc_n, addr_n;
  logic req_n, push, room, room_after;
  logic [CW-1:0] count;
  logic [63:0] head;
  assign {instr_pc, instr_out} = head;
  assign room = int'(count) < FIFO_DEPTH;
  assign room_after = int'(count) + 1 < FIFO_DEPTH;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (instr_valid && instr_ready),
    .din   ({mem_addr, mem_rdata}),
    .count (count),
    .valid (instr_valid),
    .dout  (head)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fetch_pc <= BOOT_ADDRESS;
      mem_req <= 1'b0;
      mem_addr <= BOOT_ADDRESS;
    end else begin
      state <= state_n;
      fetch_pc <= pc_n;
      mem_req <= req_n;
      mem_addr <= addr_n;
    end
  end
  // A redirect always retargets fetch_pc; an ack in IDLE is stale and ignored.
  always_comb begin
    state_n = state;
    pc_n = redirect_valid ? (redirect_addr & ~32'h3) : fetch_pc;
    req_n = mem_req;
    addr_n = mem_addr;
    push = 1'b0;
    if (state == IDLE) begin
      if (!redirect_valid && room) begin
        state_n = WAIT;
        req_n = 1'b1;
        addr_n = fetch_pc;
      end
    end else if (mem_ack) begin
      if (state == WAIT && !redirect_valid) begin
        push = 1'b1;
        pc_n = mem_addr + PC_STEP;
        addr_n = mem_addr + PC_STEP;
        req_n = room_after;
        state_n = room_after ? WAIT : IDLE;
      end else begin
        state_n = IDLE;
        req_n = 1'b0;
      end
    end else if (redirect_valid) begin
      state_n = DRAIN;
    end
  end
`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) fetch_misaligned <= 1'b0;
    else if (redirect_valid && redirect_addr[1:0] != 2'b00) fetch_misaligned <= 1'b1;
  end
`endif
endmodule
